// File: rtl/if_id_latch.sv
// IF/ID pipeline boundary register: stall hold, flush-to-NOP, post-reset warm-up, pending interrupt.
// Optional performance counters are enabled by defining IFID_PERF_EN.
module if_id_latch #(
    parameter logic [31:0] NOP_INSTR     = 32'h0000_0000,
    parameter int          WARMUP_CYCLES = 1,
    parameter int          CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush_in,
    input  logic             flush,
    input  logic [31:0]      pc_plus_4,
    input  logic [31:0]      mem_rdata,
    input  logic             interrupt,
    output logic [31:0]      id_instr,
    output logic [31:0]      id_pc_plus_4,
    output logic             id_interrupt,
    output logic             id_valid,
    output logic             int_pending,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    // state | meaning
    // WARM  | memory read data not yet trusted, bubbles loaded
    // RUN   | normal capture
    // HOLD  | stalled, id_* frozen
    typedef enum logic [1:0] {
        ST_WARM = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  warm_cnt_q, warm_cnt_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_q, pc_d;
    logic        intr_q, intr_d;
    logic        valid_q, valid_d;
    logic        pend_q, pend_d;
    logic        kill;
    logic        active;

    assign kill   = flush | flush_in;
    assign active = (state_q == ST_RUN) || (state_q == ST_HOLD);

    always_comb begin
        state_d    = state_q;
        warm_cnt_d = warm_cnt_q;
        instr_d    = instr_q;
        pc_d       = pc_q;
        intr_d     = intr_q;
        valid_d    = valid_q;
        pend_d     = pend_q;
        case (state_q)
            ST_WARM: begin
                instr_d = NOP_INSTR;
                valid_d = 1'b0;
                intr_d  = 1'b0;
                if (warm_cnt_q <= 3'd1) begin
                    warm_cnt_d = 3'd0;
                    state_d    = ST_RUN;
                end else begin
                    warm_cnt_d = warm_cnt_q - 3'd1;
                end
            end
            ST_RUN, ST_HOLD: begin
                if (kill) begin
                    instr_d = NOP_INSTR;
                    valid_d = 1'b0;
                    intr_d  = 1'b0;
                    state_d = ST_RUN;
                end else if (stall) begin
                    // a pulse arriving while frozen must not be lost
                    if (interrupt) pend_d = 1'b1;
                    state_d = ST_HOLD;
                end else begin
                    instr_d = mem_rdata;
                    pc_d    = pc_plus_4;
                    valid_d = 1'b1;
                    intr_d  = interrupt | pend_q;
                    pend_d  = 1'b0;
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d    = ST_WARM;
                warm_cnt_d = 3'(WARMUP_CYCLES);
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_WARM;
            warm_cnt_q <= 3'(WARMUP_CYCLES);
            instr_q    <= NOP_INSTR;
            pc_q       <= 32'h0;
            intr_q     <= 1'b0;
            valid_q    <= 1'b0;
            pend_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            warm_cnt_q <= warm_cnt_d;
            instr_q    <= instr_d;
            pc_q       <= pc_d;
            intr_q     <= intr_d;
            valid_q    <= valid_d;
            pend_q     <= pend_d;
        end
    end

    assign id_instr     = instr_q;
    assign id_pc_plus_4 = pc_q;
    assign id_interrupt = intr_q;
    assign id_valid     = valid_q;
    assign int_pending  = pend_q;

`ifdef IFID_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // both counters saturate at all-ones
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (active && kill && (flush_cnt_q != {CNT_W{1'b1}}))
            flush_cnt_d = flush_cnt_q + 1'b1;
        if (active && !kill && stall && (stall_cnt_q != {CNT_W{1'b1}}))
            stall_cnt_d = stall_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    logic unused_active;
    assign unused_active = active;
    assign stall_cnt     = '0;
    assign flush_cnt     = '0;
`endif

endmodule
